// File: rtl/poly_horner.sv
// poly_horner: evaluates sum(c_k * X^k) mod 2^W by Horner's rule, one
// multiply-accumulate per cycle on a single shared W x W multiplier.
// FSM: IDLE -> MAC (DEG cycles) -> DONE (one cycle, pronto pulse) -> IDLE.
// Optional build macro POLY_HORNER_OVF_EN enables the sticky overflow flag;
// without it ovf is tied to 0 and no detection logic exists.
module poly_horner #(
  parameter int W   = 16,
  parameter int DEG = 2
) (
  input  logic                 ck,
  input  logic                 rst,
  input  logic                 inicio,
  input  logic [W-1:0]         X,
  input  logic [(DEG+1)*W-1:0] COEF,
  output logic [W-1:0]         Resultado,
  output logic                 pronto,
  output logic                 ocupado,
  output logic                 ovf
);

  // Index width is sized for DEG+1 values so DEG=1 still gets a 1-bit index.
  localparam int IW = $clog2(DEG + 1);
  localparam int NSEL = 2 ** IW;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t          state_reg;
  logic [W-1:0]    x_reg;
  logic [W-1:0]    acc_reg;
  logic [W-1:0]    resultado_reg;
  logic [IW-1:0]   idx_reg;
  logic            pronto_reg;
  logic            ocupado_reg;
  // Only c_0..c_{DEG-1} are kept; c_DEG goes straight into the accumulator.
  logic [DEG*W-1:0] coef_reg;

  logic [W-1:0]    coef_arr [0:NSEL-1];
  logic [W-1:0]    coef_sel;
  logic [W-1:0]    mac_trunc;
  logic            start;

  assign start = (state_reg == IDLE) && inicio;

  // Unpack the latched coefficients into a power-of-two table so the index
  // width matches exactly; unused slots read as zero.
  generate
    for (genvar gi = 0; gi < NSEL; gi++) begin : g_coef
      if (gi < DEG) begin : g_used
        assign coef_arr[gi] = coef_reg[gi*W +: W];
      end else begin : g_pad
        assign coef_arr[gi] = '0;
      end
    end
  endgenerate

  assign coef_sel = coef_arr[idx_reg];

`ifdef POLY_HORNER_OVF_EN
  localparam int FW = 2 * W + 1;
  logic [FW-1:0] mac_full;
  logic          ovf_reg;

  assign mac_full  = FW'(acc_reg) * FW'(x_reg) + FW'(coef_sel);
  assign mac_trunc = mac_full[W-1:0];

  // Sticky overflow: cleared on an accepted start, set by any wide MAC step.
  always_ff @(posedge ck) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if (start) begin
      ovf_reg <= 1'b0;
    end else if (state_reg == MAC && mac_full[FW-1:W] != '0) begin
      ovf_reg <= 1'b1;
    end
  end

  assign ovf = ovf_reg;
`else
  // Bits above W cannot reach the truncated result, so the W-bit form is exact.
  assign mac_trunc = acc_reg * x_reg + coef_sel;
  assign ovf       = 1'b0;
`endif

  // Control FSM with registered outputs; operands are latched at start so
  // later input changes cannot disturb a running evaluation.
  always_ff @(posedge ck) begin
    if (rst) begin
      state_reg     <= IDLE;
      resultado_reg <= '0;
      pronto_reg    <= 1'b0;
      ocupado_reg   <= 1'b0;
      acc_reg       <= '0;
      idx_reg       <= '0;
    end else begin
      pronto_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (inicio) begin
            x_reg       <= X;
            coef_reg    <= COEF[DEG*W-1:0];
            acc_reg     <= COEF[DEG*W +: W];
            idx_reg     <= IW'(DEG - 1);
            ocupado_reg <= 1'b1;
            state_reg   <= MAC;
          end
        end
        MAC: begin
          acc_reg <= mac_trunc;
          if (idx_reg == '0) begin
            resultado_reg <= mac_trunc;
            pronto_reg    <= 1'b1;
            state_reg     <= DONE;
          end else begin
            idx_reg <= idx_reg - 1'b1;
          end
        end
        DONE: begin
          ocupado_reg <= 1'b0;
          state_reg   <= IDLE;
        end
        default: begin
          ocupado_reg <= 1'b0;
          state_reg   <= IDLE;
        end
      endcase
    end
  end

  assign Resultado = resultado_reg;
  assign pronto    = pronto_reg;
  assign ocupado   = ocupado_reg;

endmodule

// File: doc/poly_horner.md
POLY_HORNER -- requirements
Module: poly_horner

Interface
REQ-001 Parameter W, default 16: data width of X, each coefficient, and Resultado.
REQ-002 Parameter DEG, default 2: polynomial degree; legal range 1..15.
REQ-003 ck  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 inicio  input  1  start request; sampled only in IDLE.
REQ-006 X  input  W  evaluation point, unsigned.
REQ-007 COEF  input  (DEG+1)*W  coefficients, unsigned; COEF[(k+1)*W-1:k*W] = c_k, and c_0 is the constant term.
REQ-008 Resultado  output  W  registered result: sum of c_k*X^k, modulo 2^W.
REQ-009 pronto  output  1  one-cycle completion pulse.
REQ-010 ocupado  output  1  high in every state except IDLE.
REQ-011 ovf  output  1  sticky overflow flag (see Configuration).

Function
REQ-012 The block SHALL be an FSM with states IDLE, MAC and DONE, using one shared W x W multiplier and Horner evaluation.
REQ-013 IDLE, edge with inicio=1: latch X and all of COEF into internal registers, set acc=c_DEG and idx=DEG-1, clear ovf, then go to MAC.
REQ-014 MAC, each edge: acc = (acc*X + c_idx) truncated to W bits, then decrement idx; after the step with idx=0, write acc to Resultado and go to DONE.
REQ-015 MAC SHALL last exactly DEG cycles, so pronto is high in cycle DEG+1 after the sampling edge (edge 0).
REQ-016 DONE: pronto=1 for exactly one cycle, then unconditionally go to IDLE.
REQ-017 Resultado SHALL hold its value from DONE until the next completion; it SHALL NOT change during MAC.
REQ-018 inicio SHALL be ignored in MAC and DONE; no queuing, no restart.
REQ-019 Changes on X and COEF after the sampling edge SHALL NOT affect the running evaluation.
REQ-020 A new inicio in IDLE, in the cycle immediately after DONE, SHALL be accepted, giving back-to-back operation with a period of DEG+2 cycles.
REQ-021 All arithmetic SHALL be unsigned, with the intermediate product and sum computed at 2W+1 bits and then truncated to W bits.

Reset
REQ-022 With rst=1 at an edge: state=IDLE, Resultado=0, pronto=0, ocupado=0, ovf=0, acc=0, idx=0.
REQ-023 rst SHALL take priority over inicio and SHALL abort an evaluation in MAC or DONE with no pronto pulse.

Configuration
REQ-024 Macro POLY_HORNER_OVF_EN defined: ovf is set on any MAC step whose untruncated value is 2^W or more, stays set until the next accepted start or reset, and is valid while pronto=1.
REQ-025 Macro POLY_HORNER_OVF_EN undefined: ovf is constant 0 and no overflow-detection logic is synthesised; all other behaviour is identical.

Verification
REQ-026 W=16, DEG=2; X=3, c2=2, c1=5, c0=7; one-cycle inicio -> Resultado=40, pronto high in the 3rd cycle after the sampling edge, ocupado high 3 cycles, ovf=0.
REQ-027 W=16, DEG=2; X=300, c2=1, c1=0, c0=0 -> Resultado=24464; ovf=1 when POLY_HORNER_OVF_EN is defined, ovf=0 when it is not.
REQ-028 W=16, DEG=2; start the REQ-026 case, on the next edge change X to 9 and pulse inicio again -> Resultado=40, exactly one pronto pulse, second inicio ignored.
REQ-029 W=16, DEG=2; assert rst during MAC -> no pronto pulse, all outputs 0 next cycle; then a fresh start with X=1, c2=c1=c0=1 -> Resultado=3.
REQ-030 W=8, DEG=4; X=2, all coefficients 1 -> Resultado=31, pronto 5 cycles after the sampling edge; a second start in the cycle after DONE with X=0 -> Resultado=1.
